// File: rtl/tdm_pkg.sv
// Shared types, default sizing and the elaboration-time width check for the TDM demultiplexer.
package tdm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } tdm_state_e;

  localparam int unsigned TDM_N = 14;
  localparam int unsigned TDM_M = 4;

  // True when an m-bit counter can index every one of n slots (2^m >= n).
  function automatic bit slot_width_ok(input int unsigned n, input int unsigned m);
    return (n >= 1) && ($clog2(n) <= m);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear and enable may act in the same cycle, wraps to 0 after N-1.
module tdm_slot_counter #(
  parameter int unsigned N = 14,
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [M-1:0] cnt,
  output logic         tc
);

  logic [M-1:0] cnt_q;
  logic [M-1:0] cnt_d;
  logic [M-1:0] base;

  // clr+en together means "this beat is slot 0", so the count lands on 1.
  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (base == M'(N - 1)) ? '0 : base + M'(1);
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == M'(N - 1));

endmodule

// File: rtl/tdm_demux_n.sv
// Receive side of a counter-scanned TDM link: rebuilds N-bit frames from a serial stream.
// Optional trailing even-parity bit per frame when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux_n
  import tdm_pkg::*;
#(
  parameter int unsigned N = TDM_N,
  parameter int unsigned M = TDM_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_bit,
  input  logic         in_valid,
  input  logic         frame_start,
  output logic [N-1:0] out_word,
  output logic         out_valid,
  output logic [M-1:0] slot,
`ifdef TDM_DEMUX_PARITY_EN
  output logic         err_parity,
`endif
  output logic         err_frame
);

  if (!slot_width_ok(N, M)) begin : g_width_chk
    $error("tdm_demux_n: M is too narrow to index N slots");
  end

  localparam bit SINGLE_SLOT = (N == 1);

  tdm_state_e   state_q, state_d;
  logic [N-1:0] shift_q, shift_d;
  logic [N-1:0] out_word_q, out_word_d;
  logic         out_valid_q, out_valid_d;
  logic         err_frame_q, err_frame_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic         err_parity_q, err_parity_d;
`endif

  logic         start;
  logic         accept;
  logic         wr_last;
  logic [M-1:0] wr_idx;
  logic [N-1:0] asm_word;
  logic         cnt_clr;
  logic         cnt_en;
  logic         cnt_tc;

  tdm_slot_counter #(.N(N), .M(M)) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (slot),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    out_word_d  = out_word_q;
    out_valid_d = 1'b0;
    err_frame_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    err_parity_d = 1'b0;
`endif
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    start   = in_valid && frame_start;
    accept  = start || (in_valid && (state_q == COLLECT));
    wr_idx  = start ? '0 : slot;
    wr_last = start ? SINGLE_SLOT : cnt_tc;

    // A frame_start discards whatever was partially assembled.
    asm_word = start ? '0 : shift_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (wr_idx == M'(i)) asm_word[i] = in_bit;
    end

    if (accept) begin
      cnt_en      = 1'b1;
      cnt_clr     = start;
      err_frame_d = start && (state_q != IDLE);
      shift_d     = asm_word;
      if (wr_last) begin
`ifdef TDM_DEMUX_PARITY_EN
        state_d = PARITY;
`else
        out_word_d  = asm_word;
        out_valid_d = 1'b1;
        state_d     = IDLE;
`endif
      end else begin
        state_d = COLLECT;
      end
    end
`ifdef TDM_DEMUX_PARITY_EN
    else if (in_valid && (state_q == PARITY)) begin
      // Even parity: the parity bit equals the XOR of the data bits.
      state_d = IDLE;
      if (in_bit == ^shift_q) begin
        out_word_d  = shift_q;
        out_valid_d = 1'b1;
      end else begin
        err_parity_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      err_frame_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      err_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      err_frame_q <= err_frame_d;
`ifdef TDM_DEMUX_PARITY_EN
      err_parity_q <= err_parity_d;
`endif
    end
  end

  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign err_frame = err_frame_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign err_parity = err_parity_q;
`endif

endmodule
